// File: rtl/rf_bank_loader.sv
// rf_bank_loader: parametrised register bank with single writes, even-aligned
// pair writes and a beat-serial load engine, plus a per-register valid
// scoreboard. All register contents are exposed in parallel on rd_data.
// Optional feature macro: RF_WSTRB_EN adds byte strobes (wr_strb) to single
// writes; without it single writes are full-width.
module rf_bank_loader #(
  parameter  int DATA_W   = 512,
  parameter  int NUM_REGS = 4,
  parameter  int BEAT_W   = 128,
  localparam int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int NBEATS   = DATA_W / BEAT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic                         wr_pair,
  input  logic [AW-1:0]                wr_addr,
  input  logic [2*DATA_W-1:0]          wr_data,
`ifdef RF_WSTRB_EN
  input  logic [DATA_W/8-1:0]          wr_strb,
`endif
  input  logic                         ld_start,
  input  logic [AW-1:0]                ld_addr,
  input  logic                         ld_valid,
  input  logic [BEAT_W-1:0]            ld_data,
  output logic                         ld_ready,
  output logic                         ld_busy,
  output logic                         ld_done,
  output logic                         wr_conflict,
  input  logic [NUM_REGS-1:0]          clr_valid,
  output logic [NUM_REGS*DATA_W-1:0]   rd_data,
  output logic [NUM_REGS-1:0]          reg_valid
);

  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [AW-1:0]       tgt_r;
  logic [CW-1:0]       cnt_r;
  logic [DATA_W-1:0]   buf_r;
  logic [DATA_W-1:0]   regs_r     [NUM_REGS];
  logic [DATA_W-1:0]   regs_nxt_s [NUM_REGS];
  logic [NUM_REGS-1:0] valid_r;
  logic [NUM_REGS-1:0] valid_nxt_s;
  logic [NUM_REGS-1:0] set_s;
  logic [NUM_REGS-1:0] start_clr_s;
  logic [NUM_REGS-1:0] touch_s;
  logic [AW-1:0]       pair_lo_s;
  logic [AW-1:0]       pair_hi_s;
  logic                ld_done_r;
  logic                wr_conflict_r;
  logic                conflict_s;
  logic                ready_s;
  logic                busy_s;
  logic                start_s;
  logic                beat_s;
  logic                last_beat_s;
  logic                commit_s;

  // Load FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Load FSM next-state: start only from IDLE, leave LOAD on the last beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ld_start) state_nxt_s = ST_LOAD;
        else          state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (beat_s && last_beat_s) state_nxt_s = ST_COMMIT;
        else                       state_nxt_s = ST_LOAD;
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Load FSM outputs and handshake qualifiers decoded from the state.
  always_comb begin
    ready_s  = 1'b0;
    busy_s   = 1'b1;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE:   busy_s   = 1'b0;
      ST_LOAD:   ready_s  = 1'b1;
      ST_COMMIT: commit_s = 1'b1;
      default: begin
        ready_s  = 1'b0;
        busy_s   = 1'b0;
        commit_s = 1'b0;
      end
    endcase
    start_s     = (state_r == ST_IDLE) && ld_start;
    beat_s      = ready_s && ld_valid;
    last_beat_s = (cnt_r == CW'(NBEATS - 1));
  end

  // Load datapath: target latch, beat counter and assembly buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_r <= '0;
      cnt_r <= '0;
      buf_r <= '0;
    end else if (start_s) begin
      tgt_r <= ld_addr;
      cnt_r <= '0;
    end else if (beat_s) begin
      buf_r[cnt_r*BEAT_W +: BEAT_W] <= ld_data;
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Write arbitration: direct writes, commit priority on collision, valid update.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_nxt_s[i] = regs_r[i];
    end
    set_s       = '0;
    start_clr_s = '0;
    touch_s     = '0;
    pair_lo_s   = wr_addr & ~AW'(1);
    pair_hi_s   = pair_lo_s | AW'(1);
    if (wr_en) begin
      if (wr_pair) begin
        touch_s[pair_lo_s] = 1'b1;
        touch_s[pair_hi_s] = 1'b1;
      end else begin
        touch_s[wr_addr] = 1'b1;
      end
    end else begin
      touch_s = '0;
    end
    // A commit owns its target on this edge; the whole direct write yields.
    conflict_s = commit_s && wr_en && touch_s[tgt_r];
    if (wr_en && !conflict_s) begin
      if (wr_pair) begin
        regs_nxt_s[pair_lo_s] = wr_data[DATA_W-1:0];
        regs_nxt_s[pair_hi_s] = wr_data[2*DATA_W-1:DATA_W];
        set_s[pair_lo_s]      = 1'b1;
        set_s[pair_hi_s]      = 1'b1;
      end else begin
`ifdef RF_WSTRB_EN
        for (int j = 0; j < DATA_W/8; j++) begin
          if (wr_strb[j]) regs_nxt_s[wr_addr][j*8 +: 8] = wr_data[j*8 +: 8];
          else            regs_nxt_s[wr_addr][j*8 +: 8] = regs_r[wr_addr][j*8 +: 8];
        end
        set_s[wr_addr] = |wr_strb;
`else
        regs_nxt_s[wr_addr] = wr_data[DATA_W-1:0];
        set_s[wr_addr]      = 1'b1;
`endif
      end
    end else begin
      set_s = '0;
    end
    if (commit_s) begin
      regs_nxt_s[tgt_r] = buf_r;
      set_s[tgt_r]      = 1'b1;
    end else begin
      set_s = set_s;
    end
    if (start_s) start_clr_s[ld_addr] = 1'b1;
    else         start_clr_s = '0;
    // Setting beats any clear; both clear sources just zero the bit.
    valid_nxt_s = set_s | (valid_r & ~clr_valid & ~start_clr_s);
  end

  // Register bank, scoreboard and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
      valid_r       <= '0;
      ld_done_r     <= 1'b0;
      wr_conflict_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= regs_nxt_s[i];
      end
      valid_r       <= valid_nxt_s;
      ld_done_r     <= commit_s;
      wr_conflict_r <= conflict_s;
    end
  end

  // Flatten the register bank onto the parallel read bus.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data[i*DATA_W +: DATA_W] = regs_r[i];
    end
  end

  assign ld_ready    = ready_s;
  assign ld_busy     = busy_s;
  assign ld_done     = ld_done_r;
  assign wr_conflict = wr_conflict_r;
  assign reg_valid   = valid_r;

endmodule

// File: doc/rf_bank_loader.md
Name: rf_bank_loader

Overview:
Parametrised register bank: NUM_REGS registers of DATA_W bits, all contents exposed in parallel to the datapath. Three write paths: single-register write, even-aligned pair write (one 2*DATA_W word split across two registers), and a beat-serial load FSM that assembles one register from BEAT_W-wide beats over a valid/ready handshake. A per-register valid scoreboard tells consumers which operands are ready.

Parameters:
DATA_W, 512, register width in bits; multiple of BEAT_W and of 8.
NUM_REGS, 4, register count; even, >= 2; AW = clog2(NUM_REGS) (localparam).
BEAT_W, 128, load beat width; NBEATS = DATA_W/BEAT_W (localparam, >= 2).

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  direct write strobe
wr_pair  in  1  with wr_en: pair write; wr_addr[0] ignored
wr_addr  in  AW  direct write register index
wr_data  in  2*DATA_W  write data; single write uses [DATA_W-1:0]
ld_start  in  1  start beat load; sampled only in IDLE
ld_addr  in  AW  load target, latched on accepted ld_start
ld_valid  in  1  beat valid
ld_data  in  BEAT_W  beat payload
ld_ready  out  1  FSM accepts beat
ld_busy  out  1  FSM not IDLE
ld_done  out  1  one-cycle pulse, load committed
wr_conflict  out  1  one-cycle pulse, direct write dropped
clr_valid  in  NUM_REGS  per-register valid clear
rd_data  out  NUM_REGS*DATA_W  register i at [i*DATA_W +: DATA_W]
reg_valid  out  NUM_REGS  per-register valid scoreboard

Behaviour:
- Reset (async, rst_n=0): all registers 0, reg_valid 0, FSM IDLE, buffer and beat counter 0, ld_ready/ld_busy/ld_done/wr_conflict 0. Reset mid-load discards the partial load.
- rd_data and reg_valid driven directly from state; a write at edge N is visible after edge N.
- Single write (wr_en=1, wr_pair=0): reg[wr_addr] <= wr_data[DATA_W-1:0]; valid[wr_addr] <= 1.
- Pair write (wr_en=1, wr_pair=1): b = {wr_addr[AW-1:1],1'b0}; reg[b] <= wr_data[DATA_W-1:0], reg[b+1] <= wr_data[2*DATA_W-1:DATA_W]; both valid bits set.
- FSM states IDLE, LOAD, COMMIT.
  - IDLE: ld_start=1 -> LOAD; latch ld_addr into tgt; counter 0; valid[tgt] <= 0.
  - LOAD: ld_ready=1. On ld_valid&&ld_ready, beat k goes to buf[k*BEAT_W +: BEAT_W], k++. Acceptance of beat NBEATS-1 -> COMMIT. ld_valid=0 stalls indefinitely.
  - COMMIT: ld_ready=0. On the edge: reg[tgt] <= buf, valid[tgt] <= 1, ld_done <= 1 -> IDLE. ld_done is high in the cycle after COMMIT, coincident with new rd_data.
- ld_busy = (state != IDLE). ld_start while busy is ignored.
- Latency at full rate: ld_start accepted at edge 0, beats accepted at edges 1..NBEATS, commit at edge NBEATS+1. A new ld_start is accepted while ld_done is high.
- Collision: COMMIT writes reg[tgt] on the same edge as a direct write touching tgt (single hit, or either half of a pair) -> commit wins. The whole direct write is dropped, including the non-colliding pair half. wr_conflict pulses the next cycle.
- A direct write to tgt during LOAD is performed, sets valid, and is overwritten at commit.
- Valid priority: set (direct write or commit) > clr_valid > load-start clear, per bit.

Optional Feature:
RF_WSTRB_EN. When defined, adds input wr_strb[DATA_W/8]. A single write updates only byte j of reg[wr_addr] where wr_strb[j]=1, and sets valid only if any strobe bit is 1. Pair writes and loads ignore wr_strb. When undefined, the port is absent and single writes are full-width.

Test Plan:
- Reset then single write reg2 = 512'hA5 (low byte) -> next cycle rd_data[1535:1024] = 512'hA5, reg_valid = 4'b0100; all other registers 0.
- Pair write, wr_addr=3, wr_data = {512'h2, 512'h1} -> reg2 = 1, reg3 = 2, reg_valid[3:2] = 2'b11; reg0 and reg1 unchanged.
- Load to reg1 with beats 128'h11, 22, 33, 44 at full rate -> ld_ready high on cycles 1-4, ld_done on cycle 6, reg1 = {44,33,22,11}, valid[1] low during cycles 1-5.
- Same load with ld_valid dropped for 3 cycles after beat 2 -> same final value, ld_done 3 cycles later; ld_start pulsed mid-load is ignored.
- Single write to reg1 on the COMMIT edge -> reg1 = load data, wr_conflict pulses once; a simultaneous pair write to regs 0/1 drops both halves.
- Assert rst_n=0 after 2 beats -> ld_busy=0, regs 0; a fresh load then completes normally. With RF_WSTRB_EN and wr_strb=64'h1 -> only byte 0 changes.
